capture_ctl: RTL and testbench

- Bus-configurable sequencer that decides when ADC/pattern samples reach Packer12to8.
- Sits between the sample-source mux and the packer: drives the sample source enable and gates in_valid into out_valid.
- Supports free-run capture, fixed-length capture, and PPS-armed fixed-length capture.
- Configured over the shared 8-bit register bus driven by cmdparser.

---
 rtl/capture_ctl.sv | 214 +++++++++++++++++++++
 tb/tb_capture_ctl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctl.sv
// -----------------------------------------------------------------------------
// capture_ctl
//
// Decides when samples from the source mux reach the 12-to-8 packer. Software
// programs a sample count and arms a capture over the shared 8-bit register
// bus. A capture can free-run, stop after a fixed number of samples, or wait
// for a PPS rising edge before starting the fixed-length run.
//
// Ports:
//   clock       system clock, everything on the rising edge
//   reset       synchronous, active-high reset
//   address     register bus address
//   data        register bus data (bidirectional). Driven only while rd=1 and
//               address is inside the 6-register window, otherwise high-Z.
//   rd          bus read strobe
//   wr          bus write strobe, one write per cycle while high
//   pps         PPS level, already synchronised to clock
//   in_valid    sample strobe from the source mux
//   src_enable  enable for the sample source (high in WAIT_PPS / CAPTURE)
//   out_valid   gated sample strobe to the packer
//   busy        high in WAIT_PPS or CAPTURE
//
// Register window (offset from BASEADDR):
//   +0 CTRL    write-only pulses: b0 ARM, b1 PPS_TRIG, b2 CONT, b3 ABORT
//   +1..+3     COUNT bytes, low to high, read/write
//   +4 STATUS  read-only: b1:0 state, b2 DONE, b3 TRIG_MISSED.
//              Any write here clears DONE and TRIG_MISSED.
//   +5 NCAP    read-only count of completed captures, wraps at 255
//
// Handshake: in_valid is a single-cycle strobe with no backpressure. A sample
// is handed to the packer in the same cycle by raising out_valid; the packer
// has no ready, so every cycle with out_valid=1 transfers exactly one sample.
// -----------------------------------------------------------------------------
module capture_ctl #(
    parameter logic [7:0] BASEADDR = 8'h20,
    parameter int         CNTW     = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] address,
    inout  wire  [7:0] data,
    input  logic       rd,
    input  logic       wr,
    input  logic       pps,
    input  logic       in_valid,
    output logic       src_enable,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PPS = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [23:0]       r_count;
    logic [CNTW-1:0]   r_remaining;
    logic              r_cont;
    logic              r_pps_trig;
    logic              r_done;
    logic              r_trig_missed;
    logic [7:0]        r_ncap;
    logic              r_pps_d;

    logic [7:0]        w_offset;
    logic              w_in_window;
    logic              w_wr_win;
    logic              w_ctrl_wr;
    logic              w_abort;
    logic              w_arm;
    logic              w_pps_edge;
    logic              w_rem_zero;
    logic              w_pass;
    logic              w_finish;
    logic [7:0]        w_rd_data;

    // ---------------------------------------------------------------- decode
    assign w_offset    = address - BASEADDR;
    assign w_in_window = (w_offset < 8'd6);
    assign w_wr_win    = wr && w_in_window;
    assign w_ctrl_wr   = w_wr_win && (w_offset == 8'd0);

    // ABORT outranks ARM in the same CTRL write.
    assign w_abort = w_ctrl_wr && data[3];
    assign w_arm   = w_ctrl_wr && data[0] && !data[3] &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE));

    assign w_pps_edge = pps && !r_pps_d;
    assign w_rem_zero = (r_remaining == '0);

    // A sample passes in CAPTURE unless the fixed-length budget is spent, an
    // abort lands in the same cycle, or reset is being sampled.
    assign w_pass = (r_state == ST_CAPTURE) && in_valid &&
                    (r_cont || !w_rem_zero) && !w_abort && !reset;

    // Fixed-length run ends either on the sample that empties the budget or
    // immediately when it was armed with an empty budget.
    assign w_finish = (r_state == ST_CAPTURE) && !r_cont && !w_abort &&
                      (w_rem_zero || (w_pass && (r_remaining == CNTW'(1))));

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        src_enable   = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_arm) begin
                    w_state_next = data[1] ? ST_WAIT_PPS : ST_CAPTURE;
                end
            end
            ST_WAIT_PPS: begin
                src_enable = 1'b1;
                busy       = 1'b1;
                // The sample coincident with the edge is not passed.
                if (w_pps_edge) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                src_enable = 1'b1;
                busy       = 1'b1;
                out_valid  = w_pass;
                if (w_finish) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = ST_IDLE;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count       <= '0;
            r_remaining   <= '0;
            r_cont        <= 1'b0;
            r_pps_trig    <= 1'b0;
            r_done        <= 1'b0;
            r_trig_missed <= 1'b0;
            r_ncap        <= '0;
            r_pps_d       <= 1'b0;
        end else begin
            r_pps_d <= pps;

            if (w_wr_win) begin
                case (w_offset)
                    8'd1:    r_count[7:0]   <= data;
                    8'd2:    r_count[15:8]  <= data;
                    8'd3:    r_count[23:16] <= data;
                    default: ;
                endcase
            end

            // Budget is rounded down to even so the packer sees whole pairs.
            if (w_arm) begin
                r_remaining <= {r_count[CNTW-1:1], 1'b0};
                r_cont      <= data[2];
                r_pps_trig  <= data[1];
                r_done      <= 1'b0;
            end else if (w_pass && !r_cont) begin
                r_remaining <= r_remaining - CNTW'(1);
            end

            if (w_finish) begin
                r_done <= 1'b1;
                r_ncap <= r_ncap + 8'd1;
            end

            // A second PPS edge during a PPS-armed run is only flagged.
            if ((r_state == ST_CAPTURE) && r_pps_trig && w_pps_edge) begin
                r_trig_missed <= 1'b1;
            end

            if (w_wr_win && (w_offset == 8'd4)) begin
                r_done        <= 1'b0;
                r_trig_missed <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ read path
    always_comb begin
        w_rd_data = 8'h00;
        case (w_offset)
            8'd1:    w_rd_data = r_count[7:0];
            8'd2:    w_rd_data = r_count[15:8];
            8'd3:    w_rd_data = r_count[23:16];
            8'd4:    w_rd_data = {4'b0000, r_trig_missed, r_done, r_state};
            8'd5:    w_rd_data = r_ncap;
            default: w_rd_data = 8'h00;
        endcase
    end

    assign data = (rd && w_in_window) ? w_rd_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_capture_ctl.sv
// -----------------------------------------------------------------------------
// tb_capture_ctl
//
// Directed bench for capture_ctl: register access, fixed-length, PPS-armed and
// continuous captures, abort, NCAP wrap, sticky status clear, bus window and
// mid-capture reset. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_capture_ctl;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] address;
    wire  [7:0] data;
    logic       rd;
    logic       wr;
    logic       pps;
    logic       in_valid;
    logic       src_enable;
    logic       out_valid;
    logic       busy;

    logic [7:0] tb_drv;
    logic       tb_drv_en;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ncap = 0;

    assign data = tb_drv_en ? tb_drv : 8'bzzzz_zzzz;

    capture_ctl #(.BASEADDR(8'h20), .CNTW(24)) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .data       (data),
        .rd         (rd),
        .wr         (wr),
        .pps        (pps),
        .in_valid   (in_valid),
        .src_enable (src_enable),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    // ------------------------------------------------------ clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------------------------------------------------- driver tasks
    // Ends 1 time unit after the posedge that sampled the write.
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        address   = a;
        tb_drv    = d;
        tb_drv_en = 1'b1;
        wr        = 1'b1;
        @(posedge clock);
        #1;
        wr        = 1'b0;
        tb_drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] v);
        @(negedge clock);
        address = a;
        rd      = 1'b1;
        #1;
        v  = data;
        rd = 1'b0;
    endtask

    // Bench holds 0 on the bus; any DUT drive shows up as a non-zero value.
    task automatic bus_read_driven(input logic [7:0] a, output logic [7:0] v);
        @(negedge clock);
        address   = a;
        tb_drv    = 8'h00;
        tb_drv_en = 1'b1;
        rd        = 1'b1;
        #1;
        v         = data;
        rd        = 1'b0;
        tb_drv_en = 1'b0;
    endtask

    task automatic write_count(input logic [23:0] c);
        bus_write(8'h21, c[7:0]);
        bus_write(8'h22, c[15:8]);
        bus_write(8'h23, c[23:16]);
    endtask

    // Samples n cycles; pps level for cycle i is pat[i] (0 past bit 63).
    task automatic capture_window(input int n, input logic [63:0] pat,
                                  output int pulses, output int first_p,
                                  output int last_p, output int first_off);
        pulses = 0; first_p = -1; last_p = -1; first_off = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            pps = (i < 64) ? pat[i] : 1'b0;
            #1;
            if (out_valid) begin
                pulses++;
                if (first_p < 0) first_p = i;
                last_p = i;
            end
            if (!src_enable && first_off < 0) first_off = i;
        end
    endtask

    // ------------------------------------------------------------ main flow
    initial begin
        logic [7:0]  v;
        logic [23:0] cnt;
        int pulses, first_p, last_p, first_off, total, nloop;

        reset = 1'b1; rd = 1'b0; wr = 1'b0; pps = 1'b0; in_valid = 1'b0;
        address = 8'h00; tb_drv = 8'h00; tb_drv_en = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b1;
        #1;
        check("rst_src_enable", src_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        bus_read(8'h24, v); check("rst_status", v, 8'h00);
        bus_read(8'h25, v); check("rst_ncap", v, 8'h00);

        // COUNT register read/write
        write_count(24'h123456);
        bus_read(8'h21, v); cnt[7:0]   = v;
        bus_read(8'h22, v); cnt[15:8]  = v;
        bus_read(8'h23, v); cnt[23:16] = v;
        check("count_rw", cnt, 24'h123456);

        // COUNT=6: six pulses, src_enable drops right after the sixth
        write_count(24'd6);
        bus_write(8'h20, 8'h01);
        capture_window(20, 64'h0, pulses, first_p, last_p, first_off);
        exp_ncap = 1;
        check("c6_pulses", pulses, 6);
        check("c6_last", last_p, 5);
        check("c6_src_off", first_off, 6);
        bus_read(8'h24, v); check("c6_status", v, 8'h07);
        bus_read(8'h25, v); check("c6_ncap", v, exp_ncap);

        // COUNT=7: LSB dropped, six pulses
        write_count(24'd7);
        bus_write(8'h20, 8'h01);
        capture_window(20, 64'h0, pulses, first_p, last_p, first_off);
        exp_ncap = 2;
        check("c7_pulses", pulses, 6);
        bus_read(8'h25, v); check("c7_ncap", v, exp_ncap);

        // COUNT=1: empty budget, done after one cycle
        write_count(24'd1);
        bus_write(8'h20, 8'h01);
        capture_window(6, 64'h0, pulses, first_p, last_p, first_off);
        exp_ncap = 3;
        check("c1_pulses", pulses, 0);
        check("c1_src_off", first_off, 1);
        bus_read(8'h24, v); check("c1_status", v, 8'h07);

        // PPS-armed, COUNT=4, PPS rises at cycle 20
        pps = 1'b0;
        write_count(24'd4);
        bus_write(8'h20, 8'h03);
        check("pps_wait_busy", busy, 1);
        check("pps_wait_out_valid", out_valid, 0);
        capture_window(30, 64'hFFFF_FFFF_FFF0_0000, pulses, first_p, last_p, first_off);
        exp_ncap = 4;
        check("pps_pulses", pulses, 4);
        check("pps_first", first_p, 21);
        check("pps_last", last_p, 24);
        bus_read(8'h24, v); check("pps_status", v, 8'h07);

        // PPS-armed with a second edge during capture -> TRIG_MISSED
        pps = 1'b0;
        bus_write(8'h20, 8'h03);
        capture_window(12, 64'hFFFF_FFFF_FFFF_FFF4, pulses, first_p, last_p, first_off);
        exp_ncap = 5;
        check("miss_pulses", pulses, 4);
        check("miss_first", first_p, 3);
        bus_read(8'h24, v); check("miss_status", v, 8'h0F);
        bus_write(8'h24, 8'hFF);
        bus_read(8'h24, v); check("status_clear", v, 8'h03);
        pps = 1'b0;

        // Continuous capture, then ABORT coincident with a sample
        bus_write(8'h20, 8'h05);
        capture_window(1000, 64'h0, pulses, first_p, last_p, first_off);
        check("cont_pulses", pulses, 1000);
        check("cont_src_on", first_off, 32'hFFFF_FFFF);
        @(negedge clock);
        address = 8'h20; tb_drv = 8'h08; tb_drv_en = 1'b1; wr = 1'b1;
        #1;
        check("abort_drop", out_valid, 0);
        @(posedge clock);
        #1;
        wr = 1'b0; tb_drv_en = 1'b0;
        check("abort_busy", busy, 0);
        bus_read(8'h24, v); check("abort_status", v, 8'h00);
        bus_read(8'h25, v); check("abort_ncap", v, exp_ncap);

        // ARM and ABORT in one write: abort wins, DONE stays set
        write_count(24'd2);
        bus_write(8'h20, 8'h01);
        capture_window(6, 64'h0, pulses, first_p, last_p, first_off);
        exp_ncap = 6;
        check("c2_pulses", pulses, 2);
        bus_write(8'h20, 8'h09);
        bus_read(8'h24, v); check("arm_abort_status", v, 8'h04);

        // Re-ARM and COUNT rewrite during a capture affect only the next ARM
        in_valid = 1'b0;
        write_count(24'd10);
        bus_write(8'h20, 8'h01);
        write_count(24'd2);
        bus_write(8'h20, 8'h01);
        in_valid = 1'b1;
        capture_window(20, 64'h0, pulses, first_p, last_p, first_off);
        exp_ncap = 7;
        check("mid_len_kept", pulses, 10);
        bus_write(8'h20, 8'h01);
        capture_window(8, 64'h0, pulses, first_p, last_p, first_off);
        exp_ncap = 8;
        check("mid_next_len", pulses, 2);

        // Run captures until 256 have completed: NCAP wraps to 0
        nloop = 256 - exp_ncap;
        total = 0;
        for (int k = 0; k < nloop; k++) begin
            bus_write(8'h20, 8'h01);
            capture_window(4, 64'h0, pulses, first_p, last_p, first_off);
            total += pulses;
            exp_ncap = (exp_ncap + 1) % 256;
        end
        check("wrap_pulses", total, 2 * nloop);
        bus_read(8'h25, v); check("ncap_wrap", v, 8'h00);

        // Out-of-window reads leave the bus alone
        bus_read_driven(8'hA4, v); check("oow_a4", v, 8'h00);
        bus_read_driven(8'h26, v); check("oow_26", v, 8'h00);

        // Reset in the middle of a continuous capture
        bus_write(8'h20, 8'h01);
        capture_window(4, 64'h0, pulses, first_p, last_p, first_off);
        bus_read(8'h25, v); check("pre_rst_ncap", v, 8'h01);
        bus_write(8'h20, 8'h05);
        capture_window(3, 64'h0, pulses, first_p, last_p, first_off);
        check("pre_rst_pulses", pulses, 3);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        @(posedge clock);
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_src", src_enable, 0);
        @(negedge clock);
        reset = 1'b0;
        bus_read(8'h24, v); check("rst_mid_status", v, 8'h00);
        bus_read(8'h25, v); check("rst_mid_ncap", v, 8'h00);
        bus_read(8'h21, v); check("rst_mid_count", v, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
